// File: rtl/dummy_adc_multi.sv
// Multi-channel dummy ADC: scans enabled channels on a trigger edge and queues tagged samples in a FWFT FIFO.
// Build option DUMMY_ADC_RAMP_EN swaps the LFSR sample source for per-channel ramp counters.
module dummy_adc_multi #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CONV_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] RAND_SEED   = 32'd1,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ADC_TRIGGER,
    input  logic [NUM_CH-1:0]     CH_MASK,
    input  logic                  CONTINUOUS,
    input  logic                  CLEAR_OVF,
    input  logic                  DATA_READY_IN,
    output logic [DATA_WIDTH-1:0] MEASUREMENT,
    output logic [CH_W-1:0]       MEAS_CH,
    output logic                  DATA_VALID_OUT,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    output logic [LVL_W-1:0]      FIFO_LEVEL
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                state;
    logic                  trig_q;
    logic [NUM_CH-1:0]     mask_q;
    logic [CH_W-1:0]       ch;
    logic [CNT_W-1:0]      cnt;
    logic                  busy_q;
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]       mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;

    logic                  trig_edge;
    logic                  conv_done;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [DATA_WIDTH-1:0] sample;
    logic [CH_W-1:0]       lo_in;
    logic [CH_W-1:0]       lo_latched;
    logic [CH_W-1:0]       nx_ch;
    logic                  has_next;

    assign trig_edge = ADC_TRIGGER & ~trig_q;
    assign conv_done = (state == CONV) && (cnt == CNT_LAST);
    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign pop       = (level != '0) & DATA_READY_IN;
    assign push_ok   = conv_done & (~full | pop);
    assign drop      = conv_done & full & ~pop;

`ifdef DUMMY_ADC_RAMP_EN
    logic [DATA_WIDTH-1:0] ramp [NUM_CH];

    assign sample = ramp[ch];

    // Per-channel ramp advances on every completed conversion, dropped or not
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) ramp[i] <= '0;
        end else if (conv_done) begin
            ramp[ch] <= ramp[ch] + DATA_WIDTH'(1);
        end
    end
`else
    localparam logic [31:0] SEED = (RAND_SEED == 32'd0) ? 32'd1 : RAND_SEED;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic [31:0] lfsr;
    logic [31:0] lfsr_next;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign sample    = lfsr_next[DATA_WIDTH-1:0];

    // Galois LFSR steps on every completed conversion, dropped or not
    always_ff @(posedge clk) begin
        if (reset) lfsr <= SEED;
        else if (conv_done) lfsr <= lfsr_next;
    end
`endif

    // Channel selection: lowest enabled (live and latched mask) and next higher enabled
    always_comb begin
        lo_in      = '0;
        lo_latched = '0;
        nx_ch      = '0;
        has_next   = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (CH_MASK[i]) lo_in = CH_W'(i);
            if (mask_q[i]) lo_latched = CH_W'(i);
            if (mask_q[i] && (i > int'(ch))) begin
                nx_ch    = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            trig_q <= 1'b0;
            mask_q <= '0;
            ch     <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_ch[i]   <= '0;
            end
        end else begin
            trig_q <= ADC_TRIGGER;
            case (state)
                IDLE: begin
                    if (trig_edge && (CH_MASK != '0)) begin
                        mask_q <= CH_MASK;
                        ch     <= lo_in;
                        cnt    <= '0;
                        state  <= CONV;
                        busy_q <= 1'b1;
                    end
                end
                CONV: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (has_next) begin
                            ch <= nx_ch;
                        end else if (CONTINUOUS) begin
                            ch <= lo_latched;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (push_ok) begin
                mem_data[wr_ptr] <= sample;
                mem_ch[wr_ptr]   <= ch;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push_ok) - LVL_W'(pop);

            // A drop in the same cycle as a clear keeps the flag set
            if (drop) ovf_q <= 1'b1;
            else if (CLEAR_OVF) ovf_q <= 1'b0;
        end
    end

    assign MEASUREMENT    = mem_data[rd_ptr];
    assign MEAS_CH        = mem_ch[rd_ptr];
    assign DATA_VALID_OUT = (level != '0);
    assign BUSY           = busy_q;
    assign OVERFLOW       = ovf_q;
    assign FIFO_LEVEL     = level;

endmodule

// File: tb/tb_dummy_adc_multi.sv
// Self-checking bench for dummy_adc_multi: randomized sample values come from a behavioural generator model.
module tb_dummy_adc_multi;

    localparam int DW  = 32;
    localparam int NCH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ADC_TRIGGER;
    logic [NCH-1:0]  CH_MASK;
    logic            CONTINUOUS;
    logic            CLEAR_OVF;
    logic            DATA_READY_IN;
    logic [DW-1:0]   meas,  meas0;
    logic [1:0]      mch,   mch0;
    logic            valid, valid0;
    logic            busy,  busy0;
    logic            ovf,   ovf0;
    logic [3:0]      level, level0;

    int checks   = 0;
    int failures = 0;

    logic [31:0]   lfsr_m;
    logic [DW-1:0] ramp_m [NCH];

    always #5 clk = ~clk;

    dummy_adc_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CONV_CYCLES(8), .FIFO_DEPTH(8), .RAND_SEED(32'd1)) dut (
        .clk(clk), .reset(reset), .ADC_TRIGGER(ADC_TRIGGER), .CH_MASK(CH_MASK),
        .CONTINUOUS(CONTINUOUS), .CLEAR_OVF(CLEAR_OVF), .DATA_READY_IN(DATA_READY_IN),
        .MEASUREMENT(meas), .MEAS_CH(mch), .DATA_VALID_OUT(valid), .BUSY(busy),
        .OVERFLOW(ovf), .FIFO_LEVEL(level));

    dummy_adc_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CONV_CYCLES(8), .FIFO_DEPTH(8), .RAND_SEED(32'd0)) dut0 (
        .clk(clk), .reset(reset), .ADC_TRIGGER(ADC_TRIGGER), .CH_MASK(CH_MASK),
        .CONTINUOUS(CONTINUOUS), .CLEAR_OVF(CLEAR_OVF), .DATA_READY_IN(DATA_READY_IN),
        .MEASUREMENT(meas0), .MEAS_CH(mch0), .DATA_VALID_OUT(valid0), .BUSY(busy0),
        .OVERFLOW(ovf0), .FIFO_LEVEL(level0));

    // Next sample the ADC produces for channel c (seed 1, or ramp per channel)
    function automatic logic [DW-1:0] model_sample(input int c);
        logic [DW-1:0] s;
`ifdef DUMMY_ADC_RAMP_EN
        s = ramp_m[c];
        ramp_m[c] = ramp_m[c] + 1;
`else
        // x^32+x^22+x^2+x+1 in right-shifting Galois form
        lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 32'h8020_0003) : (lfsr_m >> 1);
        s = lfsr_m[DW-1:0];
        if (c < 0) s = '0;
`endif
        return s;
    endfunction

    task automatic model_reset();
        lfsr_m = 32'd1;
        for (int i = 0; i < NCH; i++) ramp_m[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ADC_TRIGGER = 1'b0; CH_MASK = '0; CONTINUOUS = 1'b0;
        CLEAR_OVF = 1'b0; DATA_READY_IN = 1'b0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_trigger();
        ADC_TRIGGER = 1'b1;
        tick();
        ADC_TRIGGER = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 40 && busy !== 1'b0; k++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout busy=%0b exp=0", name, busy);
        end
    endtask

    task automatic test_reset();
        CH_MASK = 4'b1111; DATA_READY_IN = 1'b1;
        reset = 1'b1; tick(); tick();
        checks++;
        if ({meas, mch, valid, busy, ovf, level} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {meas, mch, valid, busy, ovf, level});
        end
        do_reset();
    endtask

    task automatic test_single_scan();
        int first_valid, busy_drop;
        int e_ch[$], g_ch[$];
        logic [DW-1:0] e_d[$], g_d[$];
        do_reset();
        CH_MASK = 4'b1010; DATA_READY_IN = 1'b1;
        pulse_trigger();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_rise got=%0b exp=1", busy); end
        e_ch = '{1, 3};
        foreach (e_ch[i]) e_d.push_back(model_sample(e_ch[i]));
        first_valid = -1; busy_drop = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (valid === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                g_ch.push_back(int'(mch)); g_d.push_back(meas);
            end
            if (busy === 1'b0 && busy_drop < 0) busy_drop = k;
        end
        checks++;
        if (first_valid != 8) begin failures++; $display("FAIL t1_latency got=%0d exp=8", first_valid); end
        checks++;
        if (busy_drop != 16) begin failures++; $display("FAIL t1_busy_drop got=%0d exp=16", busy_drop); end
        checks++;
        if (g_ch.size() != 2) begin failures++; $display("FAIL t1_count got=%0d exp=2", g_ch.size()); end
        for (int i = 0; i < 2 && i < g_ch.size(); i++) begin
            checks++;
            if (g_ch[i] != e_ch[i] || g_d[i] !== e_d[i]) begin
                failures++;
                $display("FAIL t1_entry%0d got=(%0d,%0h) exp=(%0d,%0h)", i, g_ch[i], g_d[i], e_ch[i], e_d[i]);
            end
        end
    endtask

    task automatic test_trigger_filter();
        int busy_seen, rises;
        logic prev;
        int e_ch[$], g_ch[$];
        logic [DW-1:0] e_d[$], g_d[$];
        do_reset();
        CH_MASK = '0;
        pulse_trigger();
        busy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy !== 1'b0 || valid !== 1'b0) busy_seen = 1;
            tick();
        end
        checks++;
        if (busy_seen != 0) begin failures++; $display("FAIL t2_mask0_busy got=%0d exp=0", busy_seen); end

        CH_MASK = 4'b0101; DATA_READY_IN = 1'b1; ADC_TRIGGER = 1'b1;
        e_ch = '{0, 2};
        foreach (e_ch[i]) e_d.push_back(model_sample(e_ch[i]));
        rises = 0; prev = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 20) ADC_TRIGGER = 1'b0;
            if (busy === 1'b1 && prev === 1'b0) rises++;
            prev = busy;
            if (valid === 1'b1) begin g_ch.push_back(int'(mch)); g_d.push_back(meas); end
        end
        checks++;
        if (rises != 1) begin failures++; $display("FAIL t2_held_scans got=%0d exp=1", rises); end
        checks++;
        if (g_ch.size() != 2) begin failures++; $display("FAIL t2_count got=%0d exp=2", g_ch.size()); end
        for (int i = 0; i < 2 && i < g_ch.size(); i++) begin
            checks++;
            if (g_ch[i] != e_ch[i] || g_d[i] !== e_d[i]) begin
                failures++;
                $display("FAIL t2_entry%0d got=(%0d,%0h) exp=(%0d,%0h)", i, g_ch[i], g_d[i], e_ch[i], e_d[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] s[$];
        logic [DW-1:0] discard;
        do_reset();
        CH_MASK = 4'b0001; CONTINUOUS = 1'b1;
        pulse_trigger();
        for (int k = 0; k < 80; k++) tick();
        for (int i = 0; i < 10; i++) s.push_back(model_sample(0));
        checks++;
        if (level !== 4'd8) begin failures++; $display("FAIL t3_level got=%0d exp=8", level); end
        checks++;
        if (ovf !== 1'b1) begin failures++; $display("FAIL t3_overflow got=%0b exp=1", ovf); end
        checks++;
        if (meas !== s[0] || mch !== 2'd0) begin
            failures++; $display("FAIL t3_head got=(%0d,%0h) exp=(0,%0h)", mch, meas, s[0]);
        end
        CONTINUOUS = 1'b0;
        wait_idle("t3");
        discard = model_sample(0);
        CLEAR_OVF = 1'b1; tick(); CLEAR_OVF = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL t3_clear got=%0b exp=0", ovf); end
        DATA_READY_IN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (valid !== 1'b1 || meas !== s[i]) begin
                failures++; $display("FAIL t3_drain%0d got=(%0b,%0h) exp=(1,%0h)", i, valid, meas, s[i]);
            end
            tick();
        end
        checks++;
        if (level !== 4'd0 || discard === 'x) begin failures++; $display("FAIL t3_empty got=%0d exp=0", level); end
        DATA_READY_IN = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] s[$];
        do_reset();
        CH_MASK = 4'b0001; CONTINUOUS = 1'b1;
        pulse_trigger();
        for (int k = 0; k < 64; k++) tick();
        for (int i = 0; i < 9; i++) s.push_back(model_sample(0));
        checks++;
        if (level !== 4'd8) begin failures++; $display("FAIL t4_full got=%0d exp=8", level); end
        CONTINUOUS = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        DATA_READY_IN = 1'b1; tick(); DATA_READY_IN = 1'b0;
        checks++;
        if (level !== 4'd8 || ovf !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL t4_pushpop got=(lvl%0d,ovf%0b,busy%0b) exp=(lvl8,ovf0,busy0)", level, ovf, busy);
        end
        DATA_READY_IN = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (valid !== 1'b1 || meas !== s[i]) begin
                failures++; $display("FAIL t4_order%0d got=(%0b,%0h) exp=(1,%0h)", i, valid, meas, s[i]);
            end
            tick();
        end
        DATA_READY_IN = 1'b0;
    endtask

    task automatic test_reset_midconv();
        int seen;
        do_reset();
        CH_MASK = 4'b0001; CONTINUOUS = 1'b1;
        pulse_trigger();
        for (int k = 0; k < 13; k++) tick();
        checks++;
        if (level !== 4'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL t5_pre got=(lvl%0d,busy%0b) exp=(lvl1,busy1)", level, busy);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        checks++;
        if ({meas, mch, valid, busy, ovf, level} !== '0) begin
            failures++; $display("FAIL t5_outputs got=%0h exp=0", {meas, mch, valid, busy, ovf, level});
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL t5_late_push got=%0d exp=0", seen); end
        CONTINUOUS = 1'b0;
    endtask

    task automatic test_lfsr();
        logic [DW-1:0] e[$], g[$], g0[$];
        do_reset();
        CH_MASK = 4'b0001; CONTINUOUS = 1'b1; DATA_READY_IN = 1'b1;
        pulse_trigger();
        for (int i = 0; i < 3; i++) e.push_back(model_sample(0));
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 16) CONTINUOUS = 1'b0;
            if (valid === 1'b1) g.push_back(meas);
            if (valid0 === 1'b1) g0.push_back(meas0);
        end
        checks++;
        if (g.size() != 3 || g0.size() != 3) begin
            failures++; $display("FAIL t6_count got=(%0d,%0d) exp=(3,3)", g.size(), g0.size());
        end
        for (int i = 0; i < 3 && i < g.size() && i < g0.size(); i++) begin
            checks++;
            if (g[i] !== e[i]) begin failures++; $display("FAIL t6_seed1_s%0d got=%0h exp=%0h", i, g[i], e[i]); end
            checks++;
            if (g0[i] !== e[i]) begin failures++; $display("FAIL t6_seed0_s%0d got=%0h exp=%0h", i, g0[i], e[i]); end
        end
        DATA_READY_IN = 1'b0;
    endtask

    // Random mask scan: order and data follow the enabled channels ascending
    task automatic test_random_scans();
        int e_ch[$], g_ch[$];
        logic [DW-1:0] e_d[$], g_d[$];
        logic [NCH-1:0] m;
        for (int r = 0; r < 4; r++) begin
            e_ch.delete(); g_ch.delete(); e_d.delete(); g_d.delete();
            m = NCH'($urandom_range(1, 15));
            CH_MASK = m; DATA_READY_IN = 1'b1;
            pulse_trigger();
            for (int c = 0; c < NCH; c++) if (m[c]) begin e_ch.push_back(c); e_d.push_back(model_sample(c)); end
            for (int k = 0; k < 8 * NCH + 4; k++) begin
                tick();
                if (valid === 1'b1) begin g_ch.push_back(int'(mch)); g_d.push_back(meas); end
            end
            checks++;
            if (g_ch.size() != e_ch.size()) begin
                failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, g_ch.size(), e_ch.size());
            end
            for (int i = 0; i < e_ch.size() && i < g_ch.size(); i++) begin
                checks++;
                if (g_ch[i] != e_ch[i] || g_d[i] !== e_d[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_entry%0d got=(%0d,%0h) exp=(%0d,%0h)", r, i, g_ch[i], g_d[i], e_ch[i], e_d[i]);
                end
            end
        end
        DATA_READY_IN = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ADC_TRIGGER = 1'b0; CH_MASK = '0; CONTINUOUS = 1'b0;
        CLEAR_OVF = 1'b0; DATA_READY_IN = 1'b0;
        model_reset();
        test_reset();
        test_single_scan();
        test_trigger_filter();
        test_overflow();
        test_full_push_pop();
        test_reset_midconv();
        test_lfsr();
        test_random_scans();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
